// File: rtl/hardfloat_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// hardfloat_pkg: shared widths and FSM encoding for the denormalizer.
// Rev 1.0
// ------------------------------------------------------------------
package hardfloat_pkg;

  localparam int SIG_W       = 32;
  localparam int COARSE_STEP = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT8 = 2'd1,
    SHIFT1 = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/denorm_fine_shift.sv
`default_nettype none
// ------------------------------------------------------------------
// denorm_fine_shift: combinational 0..7 right shift with sticky OR.
// DENORM_ROUND_EN splits the last shifted-out bit into round_out. Rev 1.0
// ------------------------------------------------------------------
module denorm_fine_shift
  import hardfloat_pkg::*;
(
  input  logic [SIG_W-1:0] data_in,
  input  logic [2:0]       amt,
  output logic [SIG_W-1:0] data_out,
  output logic             sticky_out
`ifdef DENORM_ROUND_EN
  ,
  output logic             round_out
`endif
);

  // Set bits mark positions that fall off the bottom of the word.
  logic [7:0] lost_mask;

  always_comb begin
    lost_mask = (8'd1 << amt) - 8'd1;
    data_out  = data_in >> amt;
`ifdef DENORM_ROUND_EN
    round_out  = |(data_in[7:0] & (lost_mask & ~(lost_mask >> 1)));
    sticky_out = |(data_in[7:0] & (lost_mask >> 1));
`else
    sticky_out = |(data_in[7:0] & lost_mask);
`endif
  end

endmodule
`default_nettype wire

// File: rtl/denormalize32_seq.sv
`default_nettype none
// ------------------------------------------------------------------
// denormalize32_seq: iterative right-shift denormalizer (8-bit coarse
// steps, then one fine step). Macro DENORM_ROUND_EN adds a round port. Rev 1.0
// ------------------------------------------------------------------
module denormalize32_seq
  import hardfloat_pkg::*;
#(
  parameter int DIST_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIG_W-1:0]  in,
  input  logic [DIST_W-1:0] distance,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIG_W-1:0]  out,
  output logic              sticky
`ifdef DENORM_ROUND_EN
  ,
  output logic              round
`endif
);

  state_t              state_q, state_d;
  logic [SIG_W-1:0]    data_q, data_d;
  logic [DIST_W-1:0]   rem_q, rem_d;
  logic                sticky_q, sticky_d;
  logic                accept;
  logic                saturate;
  logic [SIG_W-1:0]    fine_data;
  logic                fine_sticky;
`ifdef DENORM_ROUND_EN
  logic                round_q, round_d;
  logic                fine_round;
`endif

  denorm_fine_shift u_fine (
    .data_in    (data_q),
    .amt        (rem_q[2:0]),
    .data_out   (fine_data),
    .sticky_out (fine_sticky)
`ifdef DENORM_ROUND_EN
    ,
    .round_out  (fine_round)
`endif
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rem_d    = rem_q;
    sticky_d = sticky_q;
`ifdef DENORM_ROUND_EN
    round_d  = round_q;
`endif
    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept   = in_valid && in_ready;
    saturate = int'(distance) >= SIG_W;

    case (state_q)
      SHIFT8: begin
        data_d = data_q >> COARSE_STEP;
`ifdef DENORM_ROUND_EN
        // Previous round bit is now below the new round position.
        round_d  = data_q[COARSE_STEP-1];
        sticky_d = sticky_q | round_q | (|data_q[COARSE_STEP-2:0]);
`else
        sticky_d = sticky_q | (|data_q[COARSE_STEP-1:0]);
`endif
        rem_d = rem_q - DIST_W'(COARSE_STEP);
        if (rem_d[DIST_W-1:3] == '0) state_d = SHIFT1;
      end
      SHIFT1: begin
        data_d = fine_data;
`ifdef DENORM_ROUND_EN
        if (rem_q[2:0] != 3'd0) begin
          round_d  = fine_round;
          sticky_d = sticky_q | round_q | fine_sticky;
        end
`else
        sticky_d = sticky_q | fine_sticky;
`endif
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: begin
      end
    endcase

    if (accept) begin
      data_d   = in;
      rem_d    = distance;
      sticky_d = 1'b0;
`ifdef DENORM_ROUND_EN
      round_d  = 1'b0;
`endif
      if (saturate) begin
        data_d  = '0;
        state_d = DONE;
`ifdef DENORM_ROUND_EN
        if (distance == DIST_W'(SIG_W)) begin
          round_d  = in[SIG_W-1];
          sticky_d = |in[SIG_W-2:0];
        end else begin
          sticky_d = |in;
        end
`else
        sticky_d = |in;
`endif
      end else if (distance[4:3] != 2'b00) begin
        state_d = SHIFT8;
      end else begin
        state_d = SHIFT1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      rem_q    <= '0;
      sticky_q <= 1'b0;
`ifdef DENORM_ROUND_EN
      round_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      rem_q    <= rem_d;
      sticky_q <= sticky_d;
`ifdef DENORM_ROUND_EN
      round_q  <= round_d;
`endif
    end
  end

  assign out_valid = (state_q == DONE);
  assign out       = data_q;
  assign sticky    = sticky_q;
`ifdef DENORM_ROUND_EN
  assign round     = round_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_denormalize32_seq.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_denormalize32_seq: vector table, hand sequences and random sweep
// against a shift-and-mask reference model. Rev 1.0
// ------------------------------------------------------------------
module tb_denormalize32_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] din;
  logic [5:0]  distance;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dout;
  logic        sticky;
`ifdef DENORM_ROUND_EN
  logic        round;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  denormalize32_seq #(.DIST_W(6)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (din),
    .distance  (distance),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout),
    .sticky    (sticky)
`ifdef DENORM_ROUND_EN
    ,
    .round     (round)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [5:0]  d;
    logic [31:0] o;
    logic        s;   // sticky without round split
    logic        rs;  // sticky with round split
    logic        r;
    int          lat;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain wide shift and mask arithmetic.
  task automatic model(input logic [31:0] a, input int d, output logic [31:0] o,
                       output logic s, output logic r, output int lat);
    logic [63:0] wide;
    wide = {32'b0, a};
    o    = (d >= 32) ? 32'd0 : a >> d;
`ifdef DENORM_ROUND_EN
    r = (d == 0) ? 1'b0 : wide[d-1];
    s = (d <= 1) ? 1'b0 : |(wide & ((64'd1 << (d - 1)) - 64'd1));
`else
    r = 1'b0;
    s = |(wide & ((64'd1 << d) - 64'd1));
`endif
    lat = (d >= 32) ? 1 : d / 8 + 2;
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [5:0] d,
                        input logic [31:0] exp_o, input logic exp_s, input logic exp_r,
                        input int exp_lat, input int hold);
    int waitc;
    int lat;
    din       = a;
    distance  = d;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(posedge clk);
      #2;
      waitc++;
    end
    if (!in_ready) begin
      check({name, " accept timeout"}, 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    din      = $urandom;
    distance = 6'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " out"}, dout, exp_o);
    check({name, " sticky"}, {31'b0, sticky}, {31'b0, exp_s});
`ifdef DENORM_ROUND_EN
    check({name, " round"}, {31'b0, round}, {31'b0, exp_r});
`else
    if (exp_r === 1'bx) check({name, " round x"}, 32'd0, 32'd1);
`endif
    if (hold > 0) begin
      out_ready = 1'b0;
      repeat (hold) begin
        @(posedge clk);
        #1;
        check({name, " hold valid"}, {31'b0, out_valid}, 32'd1);
        check({name, " hold out"}, dout, exp_o);
        check({name, " hold sticky"}, {31'b0, sticky}, {31'b0, exp_s});
        check({name, " hold in_ready"}, {31'b0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] ma;
    logic [5:0]  md;
    logic [31:0] mo;
    logic        ms;
    logic        mr;
    int          ml;

    tbl[0]  = '{a:32'h80000001, d:6'd1,  o:32'h40000000, s:1'b1, rs:1'b0, r:1'b1, lat:2};
    tbl[1]  = '{a:32'hFFFF0000, d:6'd20, o:32'h00000FFF, s:1'b1, rs:1'b1, r:1'b1, lat:4};
    tbl[2]  = '{a:32'h12345678, d:6'd40, o:32'h00000000, s:1'b1, rs:1'b1, r:1'b0, lat:1};
    tbl[3]  = '{a:32'h00000000, d:6'd63, o:32'h00000000, s:1'b0, rs:1'b0, r:1'b0, lat:1};
    tbl[4]  = '{a:32'h00000100, d:6'd8,  o:32'h00000001, s:1'b0, rs:1'b0, r:1'b0, lat:3};
    tbl[5]  = '{a:32'hDEADBEEF, d:6'd0,  o:32'hDEADBEEF, s:1'b0, rs:1'b0, r:1'b0, lat:2};
    tbl[6]  = '{a:32'hFFFFFFFF, d:6'd32, o:32'h00000000, s:1'b1, rs:1'b1, r:1'b1, lat:1};
    tbl[7]  = '{a:32'h80000000, d:6'd31, o:32'h00000001, s:1'b0, rs:1'b0, r:1'b0, lat:5};
    tbl[8]  = '{a:32'h000000FF, d:6'd8,  o:32'h00000000, s:1'b1, rs:1'b1, r:1'b1, lat:3};
    tbl[9]  = '{a:32'h40000000, d:6'd32, o:32'h00000000, s:1'b1, rs:1'b1, r:1'b0, lat:1};
    tbl[10] = '{a:32'h00000100, d:6'd9,  o:32'h00000000, s:1'b1, rs:1'b0, r:1'b1, lat:3};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    din       = 32'd0;
    distance  = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset out", dout, 32'd0);
    check("reset sticky", {31'b0, sticky}, 32'd0);
    check("reset in_ready", {31'b0, in_ready}, 32'd1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back table: each request is accepted on the edge that consumes the previous result.
    for (int i = 0; i < 11; i++) begin
`ifdef DENORM_ROUND_EN
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].d, tbl[i].o, tbl[i].rs, tbl[i].r, tbl[i].lat, 0);
`else
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].d, tbl[i].o, tbl[i].s, tbl[i].r, tbl[i].lat, 0);
`endif
    end

    // Back-pressure for 5 cycles, then a new request on the releasing edge.
    model(32'h12345678, 20, mo, ms, mr, ml);
    run_op("bp", 32'h12345678, 6'd20, mo, ms, mr, ml, 5);
    model(32'h00000100, 8, mo, ms, mr, ml);
    run_op("bp next", 32'h00000100, 6'd8, mo, ms, mr, ml, 0);

    // Drain to IDLE, then reset in the middle of SHIFT8.
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("drain valid", {31'b0, out_valid}, 32'd0);
    din      = 32'hFFFFFFFF;
    distance = 6'd24;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst valid", {31'b0, out_valid}, 32'd0);
    check("rst out", dout, 32'd0);
    check("rst sticky", {31'b0, sticky}, 32'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("post rst valid", {31'b0, out_valid}, 32'd0);
      check("post rst in_ready", {31'b0, in_ready}, 32'd1);
    end
    model(32'h0000FF00, 12, mo, ms, mr, ml);
    run_op("post rst op", 32'h0000FF00, 6'd12, mo, ms, mr, ml, 0);

    // Random sweep with occasional idle gaps and back-pressure.
    for (int k = 0; k < 60; k++) begin
      ma = $urandom;
      case ($urandom_range(0, 5))
        0: ma = 32'd0;
        1: ma = ma >> $urandom_range(0, 31);
        default: begin
        end
      endcase
      md = 6'($urandom_range(0, 63));
      model(ma, int'(md), mo, ms, mr, ml);
      run_op($sformatf("rnd%0d", k), ma, md, mo, ms, mr, ml, $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check($sformatf("rnd%0d consumed", k), {31'b0, out_valid}, 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
